lock_sequencer: RTL

//   Central FSM of the digital lock. Collects four 4-bit digits from the debounced button/switch front end.

---
 rtl/lock_sequencer_pkg.sv | 27 ++
 rtl/lock_timer.sv | 35 +++
 rtl/lock_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_sequencer_pkg.sv
// lock_sequencer_pkg
//   Shared constants for the digital-lock sequencer: FSM state encodings,
//   RGB colour codes and the digit-shift helper used by the entry logic.
//   No ports (package).
package lock_sequencer_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_ERROR   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // {R,G,B}
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_RED   = 3'b100;

  // Newest digit enters at the least-significant nibble.
  function automatic logic [15:0] shift_digit(input logic [15:0] v, input logic [3:0] d);
    return {v[11:0], d};
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer
//   10-bit loadable down-counter that times the OPEN / ERROR / LOCKOUT phases.
//   Ports:
//     clk, gen_rst   clock, asynchronous active-high reset
//     load_i         load load_val_i this cycle (has priority over tick_i)
//     load_val_i     value to load (0 clears the counter)
//     tick_i         timebase strobe, decrements a non-zero count
//     cnt_o          current count (registered)
//     expire_o       tick_i while the count is 1, i.e. the phase ends this edge
module lock_timer (
  input  logic       clk,
  input  logic       gen_rst,
  input  logic       load_i,
  input  logic [9:0] load_val_i,
  input  logic       tick_i,
  output logic [9:0] cnt_o,
  output logic       expire_o
);

  logic [9:0] cnt_q;

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      cnt_q <= 10'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != 10'd0)) begin
      cnt_q <= cnt_q - 10'd1;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = tick_i && (cnt_q == 10'd1);

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Central FSM of the digital lock: collects four digits, compares them with
//   the stored password, counts failed attempts and sequences the timed
//   OPEN / ERROR / LOCKOUT phases. All outputs are registered.
//   Optional feature macro: LOCK_PWCHANGE_EN (password change while OPEN).
//   Ports:
//     clk, gen_rst              clock, asynchronous active-high reset
//     tick_in                   timebase strobe for the timed phases
//     enter_pulse, submit_pulse debounced button pulses
//     digit_in                  switch value latched by enter_pulse
//     value_16bit               entered code, newest digit in [3:0]
//     pw_16bit                  stored password
//     lock_status               1 = locked
//     enb_inp                   1 = digit entry accepted
//     count                     digits entered (0..4)
//     error_counter             consecutive failed attempts
//     led_cnt                   remaining ticks of the current timed phase
//     rgb                       {R,G,B} status colour
module lock_sequencer
  import lock_sequencer_pkg::*;
#(
  parameter int          MAX_ERRORS    = 3,
  parameter int          OPEN_TICKS    = 10,
  parameter int          ERR_TICKS     = 3,
  parameter int          LOCKOUT_TICKS = 30,
  parameter logic [15:0] DEFAULT_PW    = 16'h0000
) (
  input  logic        clk,
  input  logic        gen_rst,
  input  logic        tick_in,
  input  logic        enter_pulse,
  input  logic        submit_pulse,
  input  logic [3:0]  digit_in,
  output logic [15:0] value_16bit,
  output logic [15:0] pw_16bit,
  output logic        lock_status,
  output logic        enb_inp,
  output logic [2:0]  count,
  output logic [2:0]  error_counter,
  output logic [9:0]  led_cnt,
  output logic [2:0]  rgb
);

  localparam logic [2:0] FULL = 3'(NUM_DIGITS);

  state_t      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  err_q, err_d;
  logic [2:0]  err_inc;
  logic        lock_q, lock_d;
  logic        enb_q, enb_d;
  logic [2:0]  rgb_q, rgb_d;
  logic [15:0] pw_cur;
  logic        go_entry;
  logic        tmr_load;
  logic [9:0]  tmr_val;
  logic        tmr_expire;

`ifdef LOCK_PWCHANGE_EN
  logic [15:0] pw_q, pw_d;
  assign pw_cur = pw_q;
`else
  assign pw_cur = DEFAULT_PW;
`endif

  assign err_inc = err_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    count_d  = count_q;
    err_d    = err_q;
    go_entry = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 10'd0;
`ifdef LOCK_PWCHANGE_EN
    pw_d     = pw_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        // A full code makes submit win; otherwise enter wins.
        if (submit_pulse && (count_q == FULL)) begin
          state_d = ST_CHECK;
        end else if (enter_pulse && (count_q < FULL)) begin
          value_d = shift_digit(value_q, digit_in);
          count_d = count_q + 3'd1;
        end
      end
      ST_CHECK: begin
        // Loading the timer here also swallows any tick in this cycle.
        tmr_load = 1'b1;
        if (value_q == pw_cur) begin
          state_d = ST_OPEN;
          err_d   = 3'd0;
          tmr_val = 10'(OPEN_TICKS);
`ifdef LOCK_PWCHANGE_EN
          // Start a fresh entry buffer for a possible new password.
          value_d = 16'd0;
          count_d = 3'd0;
`endif
        end else begin
          err_d = err_inc;
          if (err_inc == 3'(MAX_ERRORS)) begin
            state_d = ST_LOCKOUT;
            tmr_val = 10'(LOCKOUT_TICKS);
          end else begin
            state_d = ST_ERROR;
            tmr_val = 10'(ERR_TICKS);
          end
        end
      end
      ST_OPEN: begin
`ifdef LOCK_PWCHANGE_EN
        if (submit_pulse) begin
          if (count_q == FULL) pw_d = value_q;
          go_entry = 1'b1;
        end else begin
          if (enter_pulse && (count_q < FULL)) begin
            value_d = shift_digit(value_q, digit_in);
            count_d = count_q + 3'd1;
          end
          if (tmr_expire) go_entry = 1'b1;
        end
`else
        if (submit_pulse || tmr_expire) go_entry = 1'b1;
`endif
      end
      ST_ERROR: begin
        if (tmr_expire) go_entry = 1'b1;
      end
      ST_LOCKOUT: begin
        if (tmr_expire) begin
          go_entry = 1'b1;
          err_d    = 3'd0;
        end
      end
      default: begin
        go_entry = 1'b1;
      end
    endcase

    if (go_entry) begin
      state_d  = ST_ENTRY;
      value_d  = 16'd0;
      count_d  = 3'd0;
      // Early relock must also clear the remaining-time display.
      tmr_load = 1'b1;
      tmr_val  = 10'd0;
    end
  end

  // Status outputs are decoded from the next state so they register together.
  always_comb begin
    lock_d = (state_d != ST_OPEN);
`ifdef LOCK_PWCHANGE_EN
    enb_d  = (state_d == ST_ENTRY) || (state_d == ST_OPEN);
`else
    enb_d  = (state_d == ST_ENTRY);
`endif
    case (state_d)
      ST_OPEN:               rgb_d = RGB_GREEN;
      ST_ERROR, ST_LOCKOUT:  rgb_d = RGB_RED;
      default:               rgb_d = RGB_BLUE;
    endcase
  end

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      state_q <= ST_ENTRY;
      value_q <= 16'd0;
      count_q <= 3'd0;
      err_q   <= 3'd0;
      lock_q  <= 1'b1;
      enb_q   <= 1'b1;
      rgb_q   <= RGB_BLUE;
`ifdef LOCK_PWCHANGE_EN
      pw_q    <= DEFAULT_PW;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      enb_q   <= enb_d;
      rgb_q   <= rgb_d;
`ifdef LOCK_PWCHANGE_EN
      pw_q    <= pw_d;
`endif
    end
  end

  lock_timer u_timer (
    .clk        (clk),
    .gen_rst    (gen_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (tick_in),
    .cnt_o      (led_cnt),
    .expire_o   (tmr_expire)
  );

  assign value_16bit   = value_q;
  assign pw_16bit      = pw_cur;
  assign lock_status   = lock_q;
  assign enb_inp       = enb_q;
  assign count         = count_q;
  assign error_counter = err_q;
  assign rgb           = rgb_q;

endmodule
